ws_array_ctrl: RTL and testbench

//  Sequencer for the ROWS x COLS weight-stationary PE array (pe_ws tiles).
//  One tile pass: preload the weight column stack, stream num_vecs activation vectors with per-row skew,

---
 rtl/ws_pkg.sv | 10 +
 rtl/ws_window_mask.sv | 17 +
 rtl/ws_array_ctrl.sv | 92 +++++++++
 tb/tb_ws_array_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ws_pkg.sv
// ws_pkg: shared FSM state type and sizing helpers for the weight-stationary array sequencer
package ws_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  function automatic int cnt_w(int vec_w, int rows, int cols);
    return vec_w + 1 + $clog2(rows + cols);
  endfunction
  function automatic int run_len(int nv, int rows, int cols);
    return nv + rows + cols - 1;
  endfunction
endpackage

// File: rtl/ws_window_mask.sv
// ws_window_mask: bit i is set while t-(base+i*OFFSET_STEP) lies in [0,nv)
module ws_window_mask #(
  parameter int N = 4,
  parameter int OFFSET_STEP = 1,
  parameter int CNT_W = 12
) (
  input  logic [CNT_W-1:0] t,
  input  logic [CNT_W-1:0] base,
  input  logic [CNT_W-1:0] nv,
  output logic [N-1:0]     mask
);
  for (genvar i = 0; i < N; i++) begin : g_bit
    logic [CNT_W-1:0] off;
    assign off = base + CNT_W'(i * OFFSET_STEP);
    assign mask[i] = (t >= off) && (t - off < nv);
  end
endmodule

// File: rtl/ws_array_ctrl.sv
// ws_array_ctrl: sequences weight preload, skewed activation streaming and output flagging for one tile pass
module ws_array_ctrl
  import ws_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int VEC_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VEC_W-1:0]        num_vecs,
  output logic                    busy,
  output logic                    done,
  output logic                    load_weight,
  output logic                    w_rd_en,
  output logic [$clog2(ROWS)-1:0] w_row_idx,
  output logic                    act_rd_en,
  output logic [VEC_W-1:0]        act_idx,
  output logic [ROWS-1:0]         act_row_en,
  output logic [COLS-1:0]         out_col_vld,
  output logic [VEC_W-1:0]        out_idx
);
  localparam int CNT_W = cnt_w(VEC_W, ROWS, COLS);
  localparam int RW = $clog2(ROWS);
  state_t state, state_n;
  logic [RW-1:0] lc, lc_n;
  logic [CNT_W-1:0] t, t_n, nv_w, last;
  logic [VEC_W-1:0] nv_q, nv_n;
  logic [ROWS-1:0] row_m;
  logic [COLS-1:0] col_m;
  logic run_n, act_n;
  assign last = CNT_W'(run_len(int'(nv_q), ROWS, COLS) - 1);
  assign nv_n = (state == IDLE && start) ? num_vecs : nv_q;
  assign nv_w = CNT_W'(nv_n);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      lc    <= '0;
      t     <= '0;
      nv_q  <= '0;
    end else begin
      state <= state_n;
      lc    <= lc_n;
      t     <= t_n;
      nv_q  <= nv_n;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LOAD : IDLE;
      LOAD:    state_n = (lc == RW'(ROWS - 1)) ? (nv_q == '0 ? DONE : RUN) : LOAD;
      RUN:     state_n = (t == last) ? DONE : RUN;
      default: state_n = IDLE;
    endcase
  end
  assign lc_n  = (state == LOAD && state_n == LOAD) ? lc + 1'b1 : '0;
  assign t_n   = (state == RUN && state_n == RUN) ? t + 1'b1 : '0;
  assign run_n = state_n == RUN;
  assign act_n = run_n && (t_n < nv_w);
  // Outputs are decoded from next state/count so they line up with the registered state.
  ws_window_mask #(.N(ROWS), .OFFSET_STEP(1), .CNT_W(CNT_W)) u_row_mask (
    .t(t_n), .base(CNT_W'(0)), .nv(nv_w), .mask(row_m)
  );
  ws_window_mask #(.N(COLS), .OFFSET_STEP(1), .CNT_W(CNT_W)) u_col_mask (
    .t(t_n), .base(CNT_W'(ROWS)), .nv(nv_w), .mask(col_m)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      load_weight <= 1'b0;
      w_rd_en     <= 1'b0;
      w_row_idx   <= '0;
      act_rd_en   <= 1'b0;
      act_idx     <= '0;
      act_row_en  <= '0;
      out_col_vld <= '0;
      out_idx     <= '0;
    end else begin
      busy        <= state_n != IDLE;
      done        <= state_n == DONE;
      load_weight <= state_n == LOAD;
      w_rd_en     <= state_n == LOAD;
      w_row_idx   <= (state_n == LOAD) ? RW'(ROWS - 1) - lc_n : '0;
      act_rd_en   <= act_n;
      act_idx     <= act_n ? t_n[VEC_W-1:0] : '0;
      act_row_en  <= run_n ? row_m : '0;
      out_col_vld <= run_n ? col_m : '0;
      out_idx     <= (run_n && col_m[0]) ? VEC_W'(t_n - CNT_W'(ROWS)) : '0;
    end
endmodule

// File: tb/tb_ws_array_ctrl.sv
// tb_ws_array_ctrl: scoreboard bench; accepted passes push a per-cycle expected trace, a negedge monitor pops and compares
module tb_ws_array_ctrl;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       lw;
    logic       wrd;
    logic [1:0] widx;
    logic       ard;
    logic [7:0] aidx;
    logic [3:0] aren;
    logic [3:0] ocv;
    logic [7:0] oidx;
  } out_t;
  logic clk = 0, rst = 0, start = 0;
  logic [7:0] num_vecs = 0;
  logic busy, done, load_weight, w_rd_en, act_rd_en;
  logic [1:0] w_row_idx;
  logic [7:0] act_idx, out_idx;
  logic [3:0] act_row_en, out_col_vld;
  out_t cur, exp_v;
  out_t q[$];
  int checks = 0, errors = 0, rem = 0, cyc = 0;
  always #5 clk = ~clk;
  ws_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .VEC_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vecs(num_vecs),
    .busy(busy), .done(done), .load_weight(load_weight), .w_rd_en(w_rd_en),
    .w_row_idx(w_row_idx), .act_rd_en(act_rd_en), .act_idx(act_idx),
    .act_row_en(act_row_en), .out_col_vld(out_col_vld), .out_idx(out_idx)
  );
  assign cur = {busy, done, load_weight, w_rd_en, w_row_idx, act_rd_en, act_idx,
                act_row_en, out_col_vld, out_idx};
  // Whole-pass expected trace: ROWS load cycles, run window (skipped when n==0), one done cycle.
  function automatic void push_pass(int n);
    out_t e;
    for (int k = 0; k < ROWS; k++) begin
      e = '0; e.busy = 1; e.lw = 1; e.wrd = 1; e.widx = 2'(ROWS - 1 - k);
      q.push_back(e);
    end
    if (n > 0)
      for (int t = 0; t < n + ROWS + COLS - 1; t++) begin
        e = '0; e.busy = 1;
        e.ard = t < n;
        e.aidx = (t < n) ? 8'(t) : 8'd0;
        for (int r = 0; r < ROWS; r++) e.aren[r] = (t - r >= 0) && (t - r < n);
        for (int c = 0; c < COLS; c++) e.ocv[c] = (t - ROWS - c >= 0) && (t - ROWS - c < n);
        e.oidx = e.ocv[0] ? 8'(t - ROWS) : 8'd0;
        q.push_back(e);
      end
    e = '0; e.busy = 1; e.done = 1;
    q.push_back(e);
  endfunction
  always @(posedge clk) begin
    cyc++;
    if (!rst) rem = 0;
    else if (rem > 0) rem--;
    else if (start) begin
      push_pass(int'(num_vecs));
      rem = ROWS + ((num_vecs == 0) ? 0 : int'(num_vecs) + ROWS + COLS - 1) + 1;
    end
  end
  always @(negedge clk)
    if (rst) begin
      exp_v = (q.size() > 0) ? q.pop_front() : out_t'(0);
      checks++;
      if (cur !== exp_v) begin
        errors++;
        $display("FAIL trace cycle %0d got %h exp %h", cyc, cur, exp_v);
      end
    end
  task automatic do_reset();
    rst = 0;
    #1;
    checks++;
    if (cur !== out_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", cur, out_t'(0));
    end
    q.delete();
    @(posedge clk);
    #3 rst = 1;
  endtask
  task automatic start_pass(int n);
    int i = 0;
    @(negedge clk);
    while (rem != 0 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    if (rem != 0) begin
      checks++; errors++;
      $display("FAIL wait_idle got busy_left=%0d exp 0", rem);
    end
    start = 1;
    num_vecs = 8'(n);
    @(posedge clk);
    #1 start = 0;
    num_vecs = 8'($urandom);
  endtask
  initial begin
    int i;
    #3 do_reset();
    start_pass(3);
    start_pass(0);
    start_pass(1);
    start_pass(255);
    for (int k = 0; k < 8; k++) start_pass($urandom_range(0, 12));
    @(negedge clk);
    while (rem != 0) @(negedge clk);
    start = 1;
    num_vecs = 8'd2;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      num_vecs = 8'($urandom_range(0, 6));
    end
    start = 0;
    start_pass(3);
    repeat (ROWS + 5) @(posedge clk);
    #2 do_reset();
    start_pass(3);
    start_pass($urandom_range(1, 9));
    i = 0;
    while ((rem != 0 || q.size() != 0) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    if (rem != 0 || q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain got pending=%0d exp 0", q.size());
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
